// File: rtl/seg_scanner_if.sv
// Display scanner bus: character register and enable in, multiplexed
// digit/segment drives and frame strobe out.
interface seg_scanner_if;
   logic [63:0] display_i;
   logic        en;
   logic [7:0]  an_o;
   logic [7:0]  seg_o;
   logic        frame_o;

   modport master (
      output display_i, en,
      input  an_o, seg_o, frame_o
   );

   modport slave (
      input  display_i, en,
      output an_o, seg_o, frame_o
   );
endinterface

// File: rtl/seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with per-digit blanking,
// frame-coherent character snapshot and registered active-low drives.
module seg_scanner #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 1000
) (
   input  logic          clk,
   input  logic          rstn,
   seg_scanner_if.slave  bus
);

   localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_PRE    = CW'(DIV - 2);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t        state_reg;
   logic [2:0]    idx_reg;
   logic [CW-1:0] cnt_reg;
   logic [63:0]   snap_reg;
   logic [7:0]    an_reg;
   logic [7:0]    seg_reg;
   logic          frame_reg;

   logic [7:0]    snap_byte [8];
   logic [2:0]    idx_next;
   logic [7:0]    next_byte;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
         assign snap_byte[gi] = snap_reg[8*gi +: 8];
      end
   endgenerate

   // Digit 0 is always shown from the byte being captured on that same edge.
   assign idx_next = idx_reg + 3'd1;
   assign next_byte = (idx_next == 3'd0) ? bus.display_i[7:0] : snap_byte[idx_next];

   function automatic logic [7:0] decode(input logic [7:0] b);
      logic [3:0] nib;
      logic       hex;
      logic [7:0] pat;
      hex = 1'b1;
      nib = b[3:0];
      pat = 8'h80;
      if (b <= 8'h0F || (b >= 8'h30 && b <= 8'h39))
         nib = b[3:0];
      else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
         nib = b[3:0] + 4'd9;
      else
         hex = 1'b0;
      if (hex) begin
         case (nib)
            4'h0: pat = 8'h3F;  4'h1: pat = 8'h06;  4'h2: pat = 8'h5B;  4'h3: pat = 8'h4F;
            4'h4: pat = 8'h66;  4'h5: pat = 8'h6D;  4'h6: pat = 8'h7D;  4'h7: pat = 8'h07;
            4'h8: pat = 8'h7F;  4'h9: pat = 8'h6F;  4'hA: pat = 8'h77;  4'hB: pat = 8'h7C;
            4'hC: pat = 8'h39;  4'hD: pat = 8'h5E;  4'hE: pat = 8'h79;  default: pat = 8'h71;
         endcase
      end else if (b == 8'h2D) begin
         pat = 8'h40;
      end else if (b == 8'h20) begin
         pat = 8'h00;
      end
      return pat;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= IDLE;
         idx_reg   <= 3'd0;
         cnt_reg   <= '0;
         snap_reg  <= 64'h0F0F0F0F0F0F0F0F;
         an_reg    <= 8'hFF;
         seg_reg   <= 8'hFF;
         frame_reg <= 1'b0;
      end else if (!bus.en) begin
         state_reg <= IDLE;
         idx_reg   <= 3'd0;
         cnt_reg   <= '0;
         an_reg    <= 8'hFF;
         seg_reg   <= 8'hFF;
         frame_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               idx_reg   <= 3'd0;
               cnt_reg   <= '0;
               snap_reg  <= bus.display_i;
               frame_reg <= 1'b0;
               if (BLANK_CYC == 0) begin
                  state_reg <= SHOW;
                  an_reg    <= 8'hFE;
                  seg_reg   <= ~decode(bus.display_i[7:0]);
               end else begin
                  state_reg <= BLANK;
                  an_reg    <= 8'hFF;
                  seg_reg   <= 8'hFF;
               end
            end
            BLANK: begin
               if (cnt_reg == BLANK_LAST) begin
                  state_reg <= SHOW;
                  cnt_reg   <= '0;
                  an_reg    <= ~(8'b1 << idx_reg);
                  seg_reg   <= ~decode(snap_byte[idx_reg]);
                  frame_reg <= (DIV == 1) && (idx_reg == 3'd7);
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            SHOW: begin
               if (cnt_reg == DIV_LAST) begin
                  idx_reg <= idx_next;
                  cnt_reg <= '0;
                  if (idx_next == 3'd0)
                     snap_reg <= bus.display_i;
                  if (BLANK_CYC == 0) begin
                     state_reg <= SHOW;
                     an_reg    <= ~(8'b1 << idx_next);
                     seg_reg   <= ~decode(next_byte);
                     frame_reg <= (DIV == 1) && (idx_next == 3'd7);
                  end else begin
                     state_reg <= BLANK;
                     an_reg    <= 8'hFF;
                     seg_reg   <= 8'hFF;
                     frame_reg <= 1'b0;
                  end
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
                  // Raise the strobe so it is high exactly during the final SHOW cycle of digit 7.
                  frame_reg <= (DIV >= 2) && (idx_reg == 3'd7) && (cnt_reg == DIV_PRE);
               end
            end
            default: begin
               state_reg <= IDLE;
               an_reg    <= 8'hFF;
               seg_reg   <= 8'hFF;
               frame_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.an_o    = an_reg;
   assign bus.seg_o   = seg_reg;
   assign bus.frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scanner.sv
// Scoreboard bench for seg_scanner: per-cycle expected drives are queued
// when stimulus is applied and compared one cycle at a time.
module tb_seg_scanner;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   seg_scanner_if ifa ();
   seg_scanner_if ifb ();

   seg_scanner #(.DIV(4), .BLANK_CYC(1)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
   seg_scanner #(.DIV(3), .BLANK_CYC(0)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       frame;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic use_b    = 1'b0;
   int   cyc      = 0;

   logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] exp_seg(input logic [7:0] b);
      logic [7:0] i;
      logic [7:0] p;
      if (b < 8'd16)                        begin i = b;          p = glyph[i[3:0]]; end
      else if (b >= "0" && b <= "9")        begin i = b - 8'h30;  p = glyph[i[3:0]]; end
      else if (b >= "A" && b <= "F")        begin i = b - 8'h37;  p = glyph[i[3:0]]; end
      else if (b >= "a" && b <= "f")        begin i = b - 8'h57;  p = glyph[i[3:0]]; end
      else if (b == "-")                    p = 8'h40;
      else if (b == " ")                    p = 8'h00;
      else                                  p = 8'h80;
      return ~p;
   endfunction

   task automatic push_frame(input logic [63:0] d, input int div, input int blank, input int ncyc);
      exp_t e;
      int   c = 0;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < blank; j++) begin
            e.an = 8'hFF; e.seg = 8'hFF; e.frame = 1'b0;
            if (c < ncyc) sb.push_back(e);
            c++;
         end
         for (int j = 0; j < div; j++) begin
            e.an    = ~(8'h01 << k);
            e.seg   = exp_seg(d[8*k +: 8]);
            e.frame = (k == 7) && (j == div - 1);
            if (c < ncyc) sb.push_back(e);
            c++;
         end
      end
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      e.an = 8'hFF; e.seg = 8'hFF; e.frame = 1'b0;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic run_sb(input int n);
      exp_t e;
      for (int i = 0; i < n && sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         e = sb.pop_front();
         if (use_b) begin
            check("an_b",    ifb.an_o,    e.an);
            check("seg_b",   ifb.seg_o,   e.seg);
            check("frame_b", ifb.frame_o, e.frame);
         end else begin
            check("an_a",    ifa.an_o,    e.an);
            check("seg_a",   ifa.seg_o,   e.seg);
            check("frame_a", ifa.frame_o, e.frame);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] d_old;
      logic [63:0] d_new;

      rstn = 1'b0;
      ifa.en = 1'b0; ifa.display_i = '0;
      ifb.en = 1'b0; ifb.display_i = '0;
      #12;
      check("rst_an_a",    ifa.an_o,    8'hFF);
      check("rst_seg_a",   ifa.seg_o,   8'hFF);
      check("rst_frame_a", ifa.frame_o, 1'b0);
      check("rst_an_b",    ifb.an_o,    8'hFF);
      check("rst_seg_b",   ifb.seg_o,   8'hFF);
      @(posedge clk); #1;
      rstn = 1'b1;

      // held idle until en rises
      push_idle(2);
      run_sb(2);

      // scenario 1: all bytes 0x0F, two frames
      ifa.display_i = 64'h0F0F0F0F0F0F0F0F;
      ifa.en = 1'b1;
      push_frame(ifa.display_i, 4, 1, 40);
      push_frame(ifa.display_i, 4, 1, 40);
      run_sb(1000);
      $display("cycle %0d: scenario 1 done", cyc);

      // scenario 2: ASCII digits, then punctuation/other bytes seamlessly
      ifa.en = 1'b0;
      push_idle(1);
      run_sb(1);
      ifa.display_i = "01234567";
      ifa.en = 1'b1;
      push_frame(ifa.display_i, 4, 1, 40);
      run_sb(1000);
      ifa.display_i = 64'h2D20_7A41_6600_0A47;
      push_frame(ifa.display_i, 4, 1, 40);
      run_sb(1000);
      $display("cycle %0d: scenario 2 done", cyc);

      // scenario 3: change input while digit 3 is shown
      d_old = 64'h3938_3736_3534_3332;
      d_new = 64'h6162_6364_6566_2D20;
      ifa.display_i = d_old;
      push_frame(d_old, 4, 1, 40);
      run_sb(18);
      ifa.display_i = d_new;
      run_sb(1000);
      push_frame(d_new, 4, 1, 40);
      run_sb(1000);
      $display("cycle %0d: scenario 3 done", cyc);

      // scenario 4: drop en during digit 5 SHOW, then restart
      ifa.display_i = 64'h4142_4344_4546_3031;
      push_frame(ifa.display_i, 4, 1, 28);
      run_sb(1000);
      ifa.en = 1'b0;
      ifa.display_i = 64'h0102_0304_0506_0708;
      push_idle(3);
      run_sb(1000);
      ifa.en = 1'b1;
      push_frame(ifa.display_i, 4, 1, 40);
      run_sb(1000);
      $display("cycle %0d: scenario 4 done", cyc);

      // scenario 6: asynchronous reset mid-SHOW
      ifa.display_i = 64'h3031_3233_3435_3637;
      push_frame(ifa.display_i, 4, 1, 14);
      run_sb(1000);
      #3;
      rstn = 1'b0;
      #1;
      check("async_an",    ifa.an_o,    8'hFF);
      check("async_seg",   ifa.seg_o,   8'hFF);
      check("async_frame", ifa.frame_o, 1'b0);
      @(posedge clk); #1;
      check("held_an", ifa.an_o, 8'hFF);
      ifa.display_i = 64'h0A0B_0C0D_0E0F_2D20;
      rstn = 1'b1;
      push_frame(ifa.display_i, 4, 1, 40);
      run_sb(1000);
      ifa.en = 1'b0;
      push_idle(1);
      run_sb(1);
      $display("cycle %0d: scenario 6 done", cyc);

      // scenario 5: no blanking, DIV=3, two seamless frames
      use_b = 1'b1;
      ifb.display_i = 64'h3736_3534_3332_3130;
      ifb.en = 1'b1;
      push_frame(ifb.display_i, 3, 0, 24);
      push_frame(ifb.display_i, 3, 0, 24);
      run_sb(1000);
      ifb.en = 1'b0;
      push_idle(2);
      run_sb(1000);
      $display("cycle %0d: scenario 5 done", cyc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
